// File: rtl/fb_ram_fill_pkg.sv
// Shared types and default frame dimensions for the OTTER VGA framebuffer.
package fb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  localparam int FB_H_DEFAULT     = 320;
  localparam int FB_V_DEFAULT     = 240;
  localparam int FB_COLOR_DEFAULT = 12;

endpackage

// File: rtl/fb_ram_fill_if.sv
// Bundle of the CPU/display-side framebuffer signals, for benches and integration wrappers.
interface fb_ram_fill_if #(
  parameter int ADDR_W     = 17,
  parameter int COLOR_BITS = 12
);
  logic                  we;
  logic [ADDR_W-1:0]     wa1;
  logic [COLOR_BITS-1:0] wd;
  logic [COLOR_BITS-1:0] rd1;
  logic [ADDR_W-1:0]     ra2;
  logic [COLOR_BITS-1:0] rd2;
  logic                  fill_start;
  logic [COLOR_BITS-1:0] fill_color;
  logic                  busy;
  logic                  fill_done;

  modport master (
    output we, wa1, wd, ra2, fill_start, fill_color,
    input  rd1, rd2, busy, fill_done
  );

  modport slave (
    input  we, wa1, wd, ra2, fill_start, fill_color,
    output rd1, rd2, busy, fill_done
  );
endinterface

// File: rtl/fb_ram_fill_bram.sv
// Inferable dual-port block RAM: port A read/write, port B read-only, both read-first.
module fb_bram_dp #(
  parameter int DEPTH  = 76800,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 12
) (
  input  logic              clk_i,
  input  logic              a_we_i,
  input  logic              a_re_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  output logic [DATA_W-1:0] a_rdata_o,
  input  logic [ADDR_W-1:0] b_addr_i,
  output logic [DATA_W-1:0] b_rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Non-blocking reads alongside the write give old-data (read-first) behaviour.
  always_ff @(posedge clk_i) begin
    if (a_we_i) begin
      mem_q[a_addr_i] <= a_wdata_i;
    end
    if (a_re_i) begin
      a_rdata_o <= mem_q[a_addr_i];
    end
    b_rdata_o <= mem_q[b_addr_i];
  end

endmodule

// File: rtl/fb_ram_fill.sv
// VGA framebuffer with CPU port, display read port and a one-pixel-per-clock fill engine.
module fb_ram_fill
  import fb_pkg::*;
#(
  parameter  int H_PIXELS   = FB_H_DEFAULT,
  parameter  int V_PIXELS   = FB_V_DEFAULT,
  parameter  int COLOR_BITS = FB_COLOR_DEFAULT,
  localparam int DEPTH      = H_PIXELS * V_PIXELS,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  CLK_50MHz,
  input  logic                  RST_N,
  input  logic                  WE,
  input  logic [ADDR_W-1:0]     WA1,
  input  logic [COLOR_BITS-1:0] WD,
  output logic [COLOR_BITS-1:0] RD1,
  input  logic [ADDR_W-1:0]     RA2,
  output logic [COLOR_BITS-1:0] RD2,
  input  logic                  FILL_START,
  input  logic [COLOR_BITS-1:0] FILL_COLOR,
  output logic                  BUSY,
  output logic                  FILL_DONE
);

  // One extra bit so the bound stays exact when DEPTH is a power of two.
  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  fill_state_t           state_q;
  logic [ADDR_W-1:0]     cnt_q;
  logic [COLOR_BITS-1:0] color_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  rd1_ok_q;
  logic                  rd2_ok_q;

  logic                  wa1_ok;
  logic                  ra2_ok;
  logic                  a_we;
  logic                  a_re;
  logic [ADDR_W-1:0]     a_addr;
  logic [COLOR_BITS-1:0] a_wdata;
  logic [COLOR_BITS-1:0] a_rdata;
  logic [COLOR_BITS-1:0] b_rdata;

  assign wa1_ok = ({1'b0, WA1} < DEPTH_W);
  assign ra2_ok = ({1'b0, RA2} < DEPTH_W);

  always_ff @(posedge CLK_50MHz or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      color_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (FILL_START) begin
            state_q <= FILL;
            cnt_q   <= '0;
            color_q <= FILL_COLOR;
            busy_q  <= 1'b1;
          end
        end
        FILL: begin
          if (cnt_q == LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Port A read is disabled while filling so RD1 keeps the last CPU read.
  always_comb begin
    a_we    = busy_q ? 1'b1    : (WE && wa1_ok);
    a_re    = !busy_q;
    a_addr  = busy_q ? cnt_q   : WA1;
    a_wdata = busy_q ? color_q : WD;
  end

  // BRAM outputs cannot be reset; these flags zero the read data after reset and for out-of-range reads.
  always_ff @(posedge CLK_50MHz or negedge RST_N) begin
    if (!RST_N) begin
      rd1_ok_q <= 1'b0;
      rd2_ok_q <= 1'b0;
    end else begin
      if (!busy_q) begin
        rd1_ok_q <= wa1_ok;
      end
      rd2_ok_q <= ra2_ok;
    end
  end

  fb_bram_dp #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(COLOR_BITS)
  ) u_bram (
    .clk_i    (CLK_50MHz),
    .a_we_i   (a_we),
    .a_re_i   (a_re),
    .a_addr_i (a_addr),
    .a_wdata_i(a_wdata),
    .a_rdata_o(a_rdata),
    .b_addr_i (RA2),
    .b_rdata_o(b_rdata)
  );

  assign RD1       = rd1_ok_q ? a_rdata : '0;
  assign RD2       = rd2_ok_q ? b_rdata : '0;
  assign BUSY      = busy_q;
  assign FILL_DONE = done_q;

endmodule

// File: tb/tb_fb_ram_fill.sv
// Directed bench for fb_ram_fill: 8x4 frame (DEPTH 32) plus a 5x5 instance for range checks.
module tb_fb_ram_fill;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  fb_ram_fill_if #(.ADDR_W(5), .COLOR_BITS(12)) bus ();

  fb_ram_fill #(.H_PIXELS(8), .V_PIXELS(4), .COLOR_BITS(12)) dut (
    .CLK_50MHz (clk),
    .RST_N     (rst_n),
    .WE        (bus.we),
    .WA1       (bus.wa1),
    .WD        (bus.wd),
    .RD1       (bus.rd1),
    .RA2       (bus.ra2),
    .RD2       (bus.rd2),
    .FILL_START(bus.fill_start),
    .FILL_COLOR(bus.fill_color),
    .BUSY      (bus.busy),
    .FILL_DONE (bus.fill_done)
  );

  // 25-entry frame: addresses 25..31 are representable but out of range.
  logic        o_we;
  logic [4:0]  o_wa, o_ra;
  logic [11:0] o_wd, o_rd1, o_rd2;
  logic        o_start, o_busy, o_done;
  logic [11:0] o_color;

  fb_ram_fill #(.H_PIXELS(5), .V_PIXELS(5), .COLOR_BITS(12)) dut_odd (
    .CLK_50MHz (clk),
    .RST_N     (rst_n),
    .WE        (o_we),
    .WA1       (o_wa),
    .WD        (o_wd),
    .RD1       (o_rd1),
    .RA2       (o_ra),
    .RD2       (o_rd2),
    .FILL_START(o_start),
    .FILL_COLOR(o_color),
    .BUSY      (o_busy),
    .FILL_DONE (o_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic read2(input logic [4:0] addr, input logic [11:0] exp, input string tag);
    bus.ra2 = addr;
    tick();
    check(tag, 32'(bus.rd2), 32'(exp));
  endtask

  // mode 1 injects CPU writes and FILL_START pulses while busy.
  task automatic fill_run(input logic [11:0] color, input int mode, input logic [11:0] rd1_exp,
                          input bit chain, input logic [11:0] next_color);
    int len;
    bus.fill_start = 1'b1;
    bus.fill_color = color;
    tick();
    bus.fill_start = 1'b0;
    bus.fill_color = 12'h000;
    bus.we         = 1'b0;
    len = 0;
    while (bus.busy && len < 100) begin
      len++;
      if (mode == 1) begin
        case (len)
          11: begin bus.we = 1'b1; bus.wa1 = 5'd31; bus.wd = 12'h123; end
          12: bus.wa1 = 5'd3;
          13: bus.we = 1'b0;
          5, 20: begin bus.fill_start = 1'b1; bus.fill_color = 12'hF00; end
          6, 21: bus.fill_start = 1'b0;
          default: ;
        endcase
      end
      if (len == 16) check("rd1_hold", 32'(bus.rd1), 32'(rd1_exp));
      tick();
    end
    check("busy_len", 32'(len), 32'd32);
    check("done_high", 32'(bus.fill_done), 32'd1);
    if (chain) begin
      bus.fill_start = 1'b1;
      bus.fill_color = next_color;
    end
    tick();
    bus.fill_start = 1'b0;
    check("done_pulse", 32'(bus.fill_done), 32'd0);
    check("busy_after", 32'(bus.busy), 32'(chain));
  endtask

  initial begin
    rst_n = 1'b0;
    bus.we = 1'b0; bus.wa1 = '0; bus.wd = '0; bus.ra2 = '0;
    bus.fill_start = 1'b0; bus.fill_color = '0;
    o_we = 1'b0; o_wa = '0; o_wd = '0; o_ra = '0; o_start = 1'b0; o_color = '0;

    // 1. reset values, then basic write/read
    tick(); tick();
    check("rst_rd1", 32'(bus.rd1), 32'd0);
    check("rst_rd2", 32'(bus.rd2), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.fill_done), 32'd0);
    rst_n = 1'b1;
    tick();
    bus.we = 1'b1; bus.wa1 = 5'd5; bus.wd = 12'hABC;
    tick();
    bus.we = 1'b0; bus.ra2 = 5'd5;
    tick();
    check("wr_rd2", 32'(bus.rd2), 32'hABC);
    check("wr_rd1", 32'(bus.rd1), 32'hABC);

    // 2. full fill
    fill_run(12'h0F0, 0, 12'hABC, 1'b0, 12'h000);
    for (int i = 0; i < 32; i++) read2(5'(i), 12'h0F0, "fill_sweep");

    // 3. CPU writes and restarts during fill are dropped
    fill_run(12'h0F0, 1, 12'h0F0, 1'b0, 12'h000);
    read2(5'd31, 12'h0F0, "drop_wr31");
    read2(5'd3, 12'h0F0, "drop_wr3");
    read2(5'd0, 12'h0F0, "no_restart_color");

    // 4. same-cycle CPU write and fill start
    bus.wa1 = 5'd3;
    tick();
    bus.we = 1'b1; bus.wd = 12'h111;
    fill_run(12'h222, 0, 12'h0F0, 1'b0, 12'h000);
    read2(5'd3, 12'h222, "start_wr_overwrite");

    // 5. back-to-back fill, reset after 10 busy cycles
    tick();
    fill_run(12'hAAA, 0, 12'h222, 1'b1, 12'h777);
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    check("rstfill_busy", 32'(bus.busy), 32'd0);
    check("rstfill_done", 32'(bus.fill_done), 32'd0);
    check("rstfill_rd1", 32'(bus.rd1), 32'd0);
    tick();
    check("rstfill_done2", 32'(bus.fill_done), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rstfill_idle", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 32; i++) read2(5'(i), (i < 10) ? 12'h777 : 12'hAAA, "partial_fill");

    // 6. read-first on both ports
    bus.we = 1'b1; bus.wa1 = 5'd7; bus.wd = 12'h0AA;
    tick();
    bus.ra2 = 5'd7; bus.wd = 12'h555;
    tick();
    bus.we = 1'b0;
    check("rf_rd1_old", 32'(bus.rd1), 32'h0AA);
    check("rf_rd2_old", 32'(bus.rd2), 32'h0AA);
    tick();
    check("rf_rd1_new", 32'(bus.rd1), 32'h555);
    check("rf_rd2_new", 32'(bus.rd2), 32'h555);

    // range checks on the 25-entry instance
    o_we = 1'b1; o_wa = 5'd24; o_wd = 12'h5A5;
    tick();
    o_wa = 5'd30; o_wd = 12'hFFF;
    tick();
    o_we = 1'b0; o_wa = 5'd24; o_ra = 5'd24;
    tick();
    check("odd_last_rd1", 32'(o_rd1), 32'h5A5);
    check("odd_last_rd2", 32'(o_rd2), 32'h5A5);
    o_wa = 5'd30; o_ra = 5'd30;
    tick();
    check("oor_rd1", 32'(o_rd1), 32'd0);
    check("oor_rd2", 32'(o_rd2), 32'd0);
    o_ra = 5'd24;
    tick();
    check("odd_keep", 32'(o_rd2), 32'h5A5);
    check("odd_busy", 32'(o_busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
